dense_input_packer: RTL and testbench

Byte-stream to vector packer in front of the dense layer core. Accepts 8-bit feature values on a valid/ready stream, assembles one frame of IN_FEATURES bytes into the flattened vector layout the core consumes (lane i at bits [i*8 +: 8]), and issues a single-cycle vector-valid strobe that drives the core's data_in_valid. It also detects malformed frames and keeps a count of vectors delivered.

---
 rtl/dense_input_packer.sv | 152 +++++++++++++++
 tb/tb_dense_input_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_input_packer.sv
// ---------------------------------------------------------------------------
// dense_input_packer
//   Packs a byte stream into one flattened IN_FEATURES-lane vector for the
//   dense layer core (lane i at bits [i*DATA_W +: DATA_W], first byte = lane 0)
//   and strobes o_vec_valid for one cycle per delivered vector.
//   Malformed frames are flagged on o_err_short / o_err_long. Delivered
//   vectors are counted in o_frame_count, which wraps modulo 2^16.
//
// Optional feature macro: DENSE_PACKER_ZERO_PAD_EN
//   defined   : a short frame is emitted, with the unfilled upper lanes zeroed.
//   undefined : a short frame is dropped, and o_err_short pulses.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_s_data       feature byte
//   i_s_valid      i_s_data / i_s_last valid
//   i_s_last       final byte of frame
//   o_s_ready      packer can accept (transfer = i_s_valid && o_s_ready)
//   o_vec_out      assembled vector, registered
//   o_vec_valid    one-cycle strobe, o_vec_out is new this cycle
//   o_err_short    one-cycle strobe, short frame dropped
//   o_err_long     one-cycle strobe with o_vec_valid, frame overran
//   o_frame_count  vectors emitted
// ---------------------------------------------------------------------------
module dense_input_packer #(
    parameter int IN_FEATURES = 128,
    parameter int DATA_W      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_W-1:0]             i_s_data,
    input  logic                          i_s_valid,
    input  logic                          i_s_last,
    output logic                          o_s_ready,
    output logic [IN_FEATURES*DATA_W-1:0] o_vec_out,
    output logic                          o_vec_valid,
    output logic                          o_err_short,
    output logic                          o_err_long,
    output logic [15:0]                   o_frame_count
);

    localparam int VW    = IN_FEATURES * DATA_W;
    localparam int IDX_W = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_FEATURES - 1);

    typedef enum logic [1:0] {S_FILL, S_EMIT, S_DROP} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [VW-1:0]    r_shadow;
    logic             r_overrun;
    logic [VW-1:0]    r_vec_out;
    logic             r_vec_valid;
    logic             r_err_short;
    logic             r_err_long;
    logic [15:0]      r_frame_count;

    logic             w_xfer;
    logic             w_at_end;
    logic [VW-1:0]    w_shadow_nxt;
    logic [VW-1:0]    w_emit_vec;

    // Ready is combinational from i_rst so it drops in the same cycle
    // that reset is asserted. EMIT is the one-cycle bubble.
    assign o_s_ready = !i_rst && (r_state != S_EMIT);
    assign w_xfer    = i_s_valid && o_s_ready;
    assign w_at_end  = (r_idx == LAST_IDX);

    // Shadow buffer with the incoming byte merged into lane r_idx. The vector
    // is loaded from this merged view on the final transfer, so o_vec_out and
    // o_vec_valid become visible together in the EMIT cycle.
    for (genvar g = 0; g < IN_FEATURES; g++) begin : g_lane
        assign w_shadow_nxt[g*DATA_W +: DATA_W] =
            (r_idx == IDX_W'(g)) ? i_s_data : r_shadow[g*DATA_W +: DATA_W];
`ifdef DENSE_PACKER_ZERO_PAD_EN
        // Lanes past the final byte still hold bytes from an older frame.
        assign w_emit_vec[g*DATA_W +: DATA_W] =
            (IDX_W'(g) <= r_idx) ? w_shadow_nxt[g*DATA_W +: DATA_W] : '0;
`else
        assign w_emit_vec[g*DATA_W +: DATA_W] = w_shadow_nxt[g*DATA_W +: DATA_W];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_FILL;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_overrun     <= 1'b0;
            r_vec_out     <= '0;
            r_vec_valid   <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_long    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_vec_valid <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_xfer) begin
                        r_shadow <= w_shadow_nxt;
                        if (w_at_end) begin
                            // A missing s_last at the final lane is an
                            // overrun: emit what we have, then discard the
                            // remainder of the frame in DROP.
                            r_vec_out     <= w_emit_vec;
                            r_vec_valid   <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_err_long    <= !i_s_last;
                            r_overrun     <= !i_s_last;
                            r_idx         <= '0;
                            r_state       <= S_EMIT;
                        end else if (i_s_last) begin
                            r_idx <= '0;
`ifdef DENSE_PACKER_ZERO_PAD_EN
                            r_vec_out     <= w_emit_vec;
                            r_vec_valid   <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_overrun     <= 1'b0;
                            r_state       <= S_EMIT;
`else
                            r_err_short   <= 1'b1;
`endif
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    r_overrun <= 1'b0;
                    r_state   <= r_overrun ? S_DROP : S_FILL;
                end
                S_DROP: begin
                    if (w_xfer && i_s_last) begin
                        r_idx   <= '0;
                        r_state <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign o_vec_out     = r_vec_out;
    assign o_vec_valid   = r_vec_valid;
    assign o_err_short   = r_err_short;
    assign o_err_long    = r_err_long;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_dense_input_packer.sv
// Directed bench for dense_input_packer (default parameters).
module tb_dense_input_packer;

    localparam int NF = 128;
    localparam int DW = 8;
    localparam int VW = NF * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [VW-1:0] vec_out;
    logic          vec_valid;
    logic          err_short;
    logic          err_long;
    logic [15:0]   frame_count;

    int            total = 0;
    int            bad   = 0;
    int            exp_cnt = 0;
    logic [VW-1:0] ev;

    always #5 clk = ~clk;

    dense_input_packer #(.IN_FEATURES(NF), .DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_s_data     (s_data),
        .i_s_valid    (s_valid),
        .i_s_last     (s_last),
        .o_s_ready    (s_ready),
        .o_vec_out    (vec_out),
        .o_vec_valid  (vec_valid),
        .o_err_short  (err_short),
        .o_err_long   (err_long),
        .o_frame_count(frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            int k;
            k = 0;
            for (int j = NF - 1; j >= 0; j--)
                if (obs[j*DW +: DW] !== exp[j*DW +: DW]) k = j;
            bad++;
            $display("FAIL %s lane=%0d observed=%0h expected=%0h", tag, k,
                     obs[k*DW +: DW], exp[k*DW +: DW]);
            $error("check %s: lane %0d differs", tag, k);
        end
    endtask

    // Presents one byte and holds it until accepted; returns #1 after the
    // accepting edge with s_valid dropped.
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout observed_ready=0 expected_ready=1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(s_ready), 0);
        chk_vec("rst_vec", vec_out, '0);
        chk("rst_vvalid", 32'(vec_valid), 0);
        chk("rst_errs", 32'(err_short), 0);
        chk("rst_errl", 32'(err_long), 0);
        chk("rst_cnt", 32'(frame_count), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(s_ready), 1);

        // ---------------- nominal 0x00..0x7F ----------------
        for (int i = 0; i < NF; i++) send(8'(i), i == NF - 1);
        for (int i = 0; i < NF; i++) ev[i*DW +: DW] = 8'(i);
        exp_cnt = 1;
        chk("nom_vvalid", 32'(vec_valid), 1);
        chk("nom_ready_emit", 32'(s_ready), 0);
        chk("nom_errs", 32'(err_short), 0);
        chk("nom_errl", 32'(err_long), 0);
        chk("nom_cnt", 32'(frame_count), 32'(exp_cnt));
        chk("nom_lane0", 32'(vec_out[7:0]), 32'h00);
        chk("nom_lane127", 32'(vec_out[1023:1016]), 32'h7F);
        chk_vec("nom_vec", vec_out, ev);
        step();
        chk("nom_vvalid_1cyc", 32'(vec_valid), 0);
        chk_vec("nom_vec_stable", vec_out, ev);

        // ---------------- gapped 0xA5 frame ----------------
        for (int i = 0; i < NF; i++) begin
            send(8'hA5, i == NF - 1);
            if (i != NF - 1) step();
        end
        for (int i = 0; i < NF; i++) ev[i*DW +: DW] = 8'hA5;
        exp_cnt++;
        chk("bp_vvalid", 32'(vec_valid), 1);
        chk("bp_cnt", 32'(frame_count), 32'(exp_cnt));
        chk_vec("bp_vec", vec_out, ev);
        // byte presented during EMIT must be held and land in lane 0
        send(8'h3C, 1'b0);
        for (int i = 1; i < NF; i++) send(8'(i), i == NF - 1);
        ev[7:0] = 8'h3C;
        for (int i = 1; i < NF; i++) ev[i*DW +: DW] = 8'(i);
        exp_cnt++;
        chk("held_vvalid", 32'(vec_valid), 1);
        chk("held_cnt", 32'(frame_count), 32'(exp_cnt));
        chk_vec("held_vec", vec_out, ev);
        step();

        // ---------------- short frame (10 bytes of 0x11) ----------------
        for (int i = 0; i < 10; i++) send(8'h11, i == 9);
`ifdef DENSE_PACKER_ZERO_PAD_EN
        for (int i = 0; i < NF; i++) ev[i*DW +: DW] = (i < 10) ? 8'h11 : 8'h00;
        exp_cnt++;
        chk("short_vvalid", 32'(vec_valid), 1);
        chk("short_errs", 32'(err_short), 0);
        chk("short_cnt", 32'(frame_count), 32'(exp_cnt));
        chk_vec("short_vec_pad", vec_out, ev);
        step();
`else
        chk("short_errs", 32'(err_short), 1);
        chk("short_vvalid", 32'(vec_valid), 0);
        chk("short_cnt", 32'(frame_count), 32'(exp_cnt));
        step();
        chk("short_errs_1cyc", 32'(err_short), 0);
        chk_vec("short_vec_kept", vec_out, ev);
`endif
        for (int i = 0; i < NF; i++) send(8'(i * 3), i == NF - 1);
        for (int i = 0; i < NF; i++) ev[i*DW +: DW] = 8'(i * 3);
        exp_cnt++;
        chk("after_short_vvalid", 32'(vec_valid), 1);
        chk("after_short_cnt", 32'(frame_count), 32'(exp_cnt));
        chk_vec("after_short_vec", vec_out, ev);
        step();

        // ---------------- long frame (130 bytes) ----------------
        for (int i = 0; i < NF; i++) ev[i*DW +: DW] = 8'(i ^ 'h5A);
        for (int i = 0; i < NF + 2; i++) begin
            send(8'(i ^ 'h5A), i == NF + 1);
            if (i == NF - 1) begin
                exp_cnt++;
                chk("long_vvalid", 32'(vec_valid), 1);
                chk("long_errl", 32'(err_long), 1);
                chk("long_cnt", 32'(frame_count), 32'(exp_cnt));
                chk_vec("long_vec", vec_out, ev);
            end else if (i >= NF) begin
                chk("long_drop_vvalid", 32'(vec_valid), 0);
                chk("long_drop_errl", 32'(err_long), 0);
                chk("long_drop_errs", 32'(err_short), 0);
            end
        end
        chk("long_drop_cnt", 32'(frame_count), 32'(exp_cnt));
        chk_vec("long_drop_vec", vec_out, ev);
        for (int i = 0; i < NF; i++) send(8'(255 - i), i == NF - 1);
        for (int i = 0; i < NF; i++) ev[i*DW +: DW] = 8'(255 - i);
        exp_cnt++;
        chk("after_long_vvalid", 32'(vec_valid), 1);
        chk("after_long_errl", 32'(err_long), 0);
        chk("after_long_cnt", 32'(frame_count), 32'(exp_cnt));
        chk_vec("after_long_vec", vec_out, ev);
        step();

        // ---------------- reset mid-frame ----------------
        for (int i = 0; i < 50; i++) send(8'h77, 1'b0);
        rst = 1'b1;
        step();
        chk("midrst_ready", 32'(s_ready), 0);
        chk_vec("midrst_vec", vec_out, '0);
        chk("midrst_vvalid", 32'(vec_valid), 0);
        chk("midrst_errs", 32'(err_short), 0);
        chk("midrst_errl", 32'(err_long), 0);
        chk("midrst_cnt", 32'(frame_count), 0);
        rst = 1'b0;
        for (int i = 0; i < NF; i++) send(8'(i + 1), i == NF - 1);
        for (int i = 0; i < NF; i++) ev[i*DW +: DW] = 8'(i + 1);
        chk("postrst_vvalid", 32'(vec_valid), 1);
        chk("postrst_cnt", 32'(frame_count), 1);
        chk_vec("postrst_vec", vec_out, ev);
        step();

        // ---------------- reset during EMIT ----------------
        for (int i = 0; i < NF; i++) send(8'h40, i == NF - 1);
        chk("emitrst_pre_cnt", 32'(frame_count), 2);
        rst = 1'b1;
        step();
        chk("emitrst_vvalid", 32'(vec_valid), 0);
        chk("emitrst_cnt", 32'(frame_count), 0);
        chk_vec("emitrst_vec", vec_out, '0);
        rst = 1'b0;
        step();

        // ---------------- counter wrap ----------------
        force dut.r_frame_count = 16'hFFFF;
        step();
        release dut.r_frame_count;
        step();
        chk("wrap_preload", 32'(frame_count), 32'hFFFF);
        for (int i = 0; i < NF; i++) send(8'h5C, i == NF - 1);
        chk("wrap_vvalid", 32'(vec_valid), 1);
        chk("wrap_cnt", 32'(frame_count), 32'h0000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
